dmem_req_ctrl: RTL
==================

Name: dmem_req_ctrl

Overview:
Initiator side of the slow data-memory handshake. It sits between the MEM stage of the pipeline processor and dmem.
- Latches one load/store per request and drives WriteEnable/ReadEnable/Address/WriteData to memory.
- Holds the pipeline in stall until memory raises done, then returns read data.
- Forces an enable-low cycle between accesses so the memory's internal latency counter restarts for every access.
- A timeout guards against a memory that never completes.

Parameters:
TIMEOUT, 64, WAIT cycles without done before the access is abandoned (must be ≥ 2)
CNT_W, 7, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT
ERR_DATA, 32'h0000_0000, value returned on cpu_rdata for a timed-out load

Ports:
CLK  in  1  clock, all state on posedge
RST  in  1  synchronous, active-high reset
cpu_req  in  1  MEM stage has a load or store this cycle; held until stall is low
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data; valid in the RESP cycle, held afterwards
stall  out  1  freeze pipeline (combinational from state and cpu_req)
mem_we  out  1  to dmem WriteEnable
mem_re  out  1  to dmem ReadEnable
mem_addr  out  32  to dmem Address, low 2 bits forced to 0
mem_wdata  out  32  to dmem WriteData
mem_rdata  in  32  from dmem ReadData
mem_done  in  1  from dmem done
timeout_err  out  1  sticky error flag; cleared only by RST

Behaviour:
- Reset (RST high at posedge):
  - state=IDLE; wait counter=0; timeout_err=0; cpu_rdata=0; latched addr/wdata/we=0.
  - mem_we=mem_re=0 and stall=0 from the next cycle.
  - RST mid-access abandons the access silently; no RESP cycle is produced.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Enables low; stall=cpu_req.
  - If cpu_req=1: latch cpu_we, cpu_addr, cpu_wdata; counter=0; go to WAIT.
- WAIT:
  - mem_we=latched we; mem_re=~latched we; mem_addr={addr[31:2],2'b00}; mem_wdata=latched wdata; stall=1; counter increments each cycle.
  - If mem_done=1: for a load, cpu_rdata<=mem_rdata (a store leaves cpu_rdata unchanged); go to RESP.
  - Else if counter==TIMEOUT-1: timeout_err<=1; for a load, cpu_rdata<=ERR_DATA; go to RESP.
  - If mem_done and the timeout condition occur in the same cycle, done wins and no error is raised.
- RESP:
  - Enables low (the mandatory recovery cycle); stall=0; pipeline advances at the end of this cycle; go to IDLE unconditionally.
  - cpu_req is not sampled in RESP; it belongs to the completed instruction.
- mem_done is ignored in IDLE and RESP; a level left high by memory must not start or complete an access.
- Back-to-back accesses:
  - The earliest new request is in the IDLE cycle after RESP.
  - Enables are therefore low for at least 2 cycles (RESP + IDLE) between accesses.
- Latency: for a memory asserting done in its D-th enabled cycle, stall is high for D+1 consecutive cycles (IDLE + D WAIT cycles), then 1 RESP cycle.
- cpu_addr[1:0] is ignored; accesses are word-only.
- Outputs mem_* are functions of state and latched registers only, with no combinational path from cpu_* to mem_*.

Decomposition:
- Package dmem_req_ctrl_pkg holds:
  - the state enum (IDLE, WAIT, RESP, 2 bits);
  - default constants for TIMEOUT and ERR_DATA.
- No sub-module is needed; the wait counter lives inline.

Test Plan:
- Load, memory model done at D=20, mem_rdata=32'hCAFE_0001 at addr 0x40:
  - stall high exactly 21 cycles; mem_re high 20 cycles, mem_addr=0x40;
  - RESP: stall=0, cpu_rdata=0xCAFE_0001, timeout_err=0.
- Store addr 0x43, wdata 0x1234_5678, D=20:
  - mem_we high 20 cycles, mem_addr=0x40, mem_wdata=0x1234_5678;
  - cpu_rdata unchanged from the previous load.
- Load immediately followed by store (cpu_req held high):
  - enables low in RESP and IDLE (2 cycles);
  - the second access shows fresh mem_addr and a new 21-cycle stall.
- Model never asserts done, TIMEOUT=64:
  - RESP after 64 WAIT cycles; cpu_rdata=0x0; timeout_err=1 and stays 1 across the next successful load.
- mem_done stuck high in IDLE with cpu_req=0:
  - no state change, enables low, stall=0.
- RST pulsed on WAIT cycle 5:
  - next cycle IDLE, enables low, stall=0 when cpu_req=0, timeout_err=0, cpu_rdata=0.

Source files
------------

// File: rtl/dmem_req_ctrl_pkg.sv
// Shared types and default constants for the data-memory request controller.
package dmem_req_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          DEF_TIMEOUT  = 64;
  localparam int          DEF_CNT_W    = 7;
  localparam logic [31:0] DEF_ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/dmem_req_ctrl.sv
// Initiator side of the slow dmem handshake: latches one MEM-stage access,
// holds the pipeline until dmem reports done (or a timeout fires), then returns.
module dmem_req_ctrl
  import dmem_req_ctrl_pkg::*;
#(
  parameter int          TIMEOUT  = DEF_TIMEOUT,
  parameter int          CNT_W    = DEF_CNT_W,
  parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  output logic        timeout_err,
  output state_t      dbg_state
);

  // Handshake: cpu_req is a request held until stall drops; the access is
  // accepted in IDLE, enables stay high for every WAIT cycle, and mem_done is
  // only honoured while enables are high. RESP is the enable-low recovery cycle.

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             we_q;
  logic [29:0]      addr_q;
  logic [31:0]      wdata_q;

  // Byte offset is dropped: every access is a full word.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr[1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      cpu_rdata   <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            we_q     <= cpu_we;
            addr_q   <= cpu_addr[31:2];
            wdata_q  <= cpu_wdata;
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // done takes priority over a timeout landing on the same cycle
          if (mem_done) begin
            if (!we_q) cpu_rdata <= mem_rdata;
            state <= RESP;
          end else if (wait_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            if (!we_q) cpu_rdata <= ERR_DATA;
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_we    = (state == WAIT) & we_q;
  assign mem_re    = (state == WAIT) & ~we_q;
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign stall     = (state == WAIT) | ((state == IDLE) & cpu_req);
  assign dbg_state = state;

endmodule
